// File: rtl/hps_spi_slave_responder_if.sv
// Fabric-side bundle of the HPS SPI slave responder: SPI pad signals plus
// the TX holding-buffer handshake and the RX word strobe.
interface hps_spi_slave_responder_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  spi_sclk_i;
   logic                  spi_mosi_i;
   logic                  spi_ss_n_i;
   logic                  spi_miso_o;
   logic                  spi_miso_oe_o;
   logic [DATA_WIDTH-1:0] tx_data_i;
   logic                  tx_valid_i;
   logic                  tx_ready_o;
   logic [DATA_WIDTH-1:0] rx_data_o;
   logic                  rx_valid_o;
   logic                  tx_underrun_o;
   logic                  busy_o;

   modport slave (
      input  spi_sclk_i, spi_mosi_i, spi_ss_n_i, tx_data_i, tx_valid_i,
      output spi_miso_o, spi_miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
             tx_underrun_o, busy_o
   );

   modport master (
      output spi_sclk_i, spi_mosi_i, spi_ss_n_i, tx_data_i, tx_valid_i,
      input  spi_miso_o, spi_miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
             tx_underrun_o, busy_o
   );
endinterface

// File: rtl/hps_spi_slave_responder.sv
// Mode-0 SPI slave for the HPS SPIM1 master, oversampled in clk_clk, with a
// one-entry TX holding buffer and a per-word RX strobe.
//
// state     | meaning
// ST_IDLE   | SS deasserted; SCLK ignored, MISO tri-stated
// ST_ACTIVE | frame in progress; shifting on SCLK edges, MISO driven
module hps_spi_slave_responder #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                    clk_clk,
   input  logic                    reset_reset_n,
   hps_spi_slave_responder_if.slave bus
);

   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

   logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
   logic                   sclk_hist_q, ss_hist_q;
   logic                   sclk_s, mosi_s, ss_s;
   logic                   sclk_rise, sclk_fall, ss_fall, ss_rise;

   state_t                 state_q, state_d;
   logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;
   logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
   logic [DATA_WIDTH-1:0]  buf_q, buf_d;
   logic                   buf_full_q, buf_full_d;
   logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   underrun_q, underrun_d;
   logic                   miso_q;
   logic                   load;

   // ss_n synchronizer resets high so reset release never looks like a frame start
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         ss_sync_q   <= '1;
         sclk_hist_q <= 1'b0;
         ss_hist_q   <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk_i};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi_i};
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], bus.spi_ss_n_i};
         sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
         ss_hist_q   <= ss_sync_q[SYNC_STAGES-1];
      end
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign ss_s      = ss_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_hist_q;
   assign sclk_fall = ~sclk_s & sclk_hist_q;
   assign ss_fall   = ~ss_s & ss_hist_q;
   assign ss_rise   = ss_s & ~ss_hist_q;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         rx_shift_q <= '0;
         tx_shift_q <= '0;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         underrun_q <= 1'b0;
         miso_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         rx_shift_q <= rx_shift_d;
         tx_shift_q <= tx_shift_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         underrun_q <= underrun_d;
         miso_q     <= tx_shift_q[DATA_WIDTH-1];
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      rx_shift_d = rx_shift_q;
      tx_shift_d = tx_shift_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      underrun_d = 1'b0;
      load       = 1'b0;

      // Word completion is honoured even if SS rises in the same cycle
      if (bit_cnt_q == CNT_FULL) begin
         bit_cnt_d  = '0;
         rx_data_d  = rx_shift_q;
         rx_valid_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (ss_fall) begin
               state_d   = ST_ACTIVE;
               bit_cnt_d = '0;
               load      = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (ss_rise) begin
               state_d    = ST_IDLE;
               bit_cnt_d  = '0;
               tx_shift_d = '0;
            end else begin
               if (sclk_rise) begin
                  rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                  bit_cnt_d  = bit_cnt_q + CNT_ONE;
               end
               if (sclk_fall) begin
                  if (bit_cnt_q == '0) begin
                     load = 1'b1;
                  end else begin
                     tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (load) begin
         if (buf_full_q) begin
            tx_shift_d = buf_q;
            buf_full_d = 1'b0;
         end else begin
            tx_shift_d = '0;
            underrun_d = 1'b1;
         end
      end

      // A write landing with a load against an empty buffer refills it for the next word
      if (bus.tx_valid_i && !buf_full_q) begin
         buf_d      = bus.tx_data_i;
         buf_full_d = 1'b1;
      end
   end

   assign bus.spi_miso_o    = miso_q;
   assign bus.spi_miso_oe_o = (state_q == ST_ACTIVE);
   assign bus.busy_o        = (state_q == ST_ACTIVE);
   assign bus.tx_ready_o    = ~buf_full_q;
   assign bus.rx_data_o     = rx_data_q;
   assign bus.rx_valid_o    = rx_valid_q;
   assign bus.tx_underrun_o = underrun_q;

endmodule
